// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences LW/LBU/SW/SB data-memory accesses for the
// execute stage, one access in flight, stalling the pipeline until done.
// Optional build macro DMEM_BYTE_MASK_EN: SB becomes a single masked write
// instead of a read-modify-write.
//
// Request channel: a request is transferred on a rising edge where
// mem_req_valid_o and mem_req_ready_i are both 1; while valid is high and
// ready is low, we/addr/wdata/mask are held stable. The response channel is
// valid-only (no backpressure) and is only observed in WAIT.
module dmem_access_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid_i,
    input  logic                  is_load_i,
    input  logic                  is_store_i,
    input  logic                  is_byte_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  misaligned_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]            mem_mask_o,
    input  logic                  mem_resp_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_resp_data_i,
    output logic [2:0]            dbg_state_o
);

`ifdef DMEM_BYTE_MASK_EN
    localparam logic BYTE_MASK = 1'b1;
`else
    localparam logic BYTE_MASK = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        RMW_WR = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                state;
    logic                  store_q;
    logic                  byte_q;
    logic [1:0]            lane_q;
    logic [7:0]            wbyte_q;
    logic                  op_store;
    logic [7:0]            resp_byte;
    logic [DATA_WIDTH-1:0] merged;

    // A set load flag wins over a set store flag.
    assign op_store    = is_store_i & ~is_load_i;
    assign dbg_state_o = state;

    // Stall while busy, and already in the cycle the op is presented.
    assign stall_o = (state == REQ) || (state == WAIT) || (state == RMW_WR) ||
                     ((state == IDLE) && op_valid_i);

    // Byte lane extraction for LBU and lane merge for the SB read-modify-write.
    always_comb begin
        resp_byte = mem_resp_data_i[{lane_q, 3'b000} +: 8];
        merged    = mem_resp_data_i;
        merged[{lane_q, 3'b000} +: 8] = wbyte_q;
    end

    // Access sequencer with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            store_q         <= 1'b0;
            byte_q          <= 1'b0;
            lane_q          <= 2'b00;
            wbyte_q         <= 8'h00;
            done_o          <= 1'b0;
            misaligned_o    <= 1'b0;
            rdata_o         <= '0;
            mem_req_valid_o <= 1'b0;
            mem_we_o        <= 1'b0;
            mem_addr_o      <= '0;
            mem_wdata_o     <= '0;
            mem_mask_o      <= 4'hF;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid_i) begin
                        store_q <= op_store;
                        byte_q  <= is_byte_i;
                        lane_q  <= addr_i[1:0];
                        wbyte_q <= wdata_i[7:0];
                        if (!is_byte_i && (addr_i[1:0] != 2'b00)) begin
                            // Misaligned word access: complete without touching memory.
                            state        <= DONE;
                            done_o       <= 1'b1;
                            misaligned_o <= 1'b1;
                            rdata_o      <= '0;
                        end else begin
                            state           <= REQ;
                            mem_req_valid_o <= 1'b1;
                            mem_addr_o      <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                            if (BYTE_MASK && op_store && is_byte_i) begin
                                mem_we_o    <= 1'b1;
                                mem_wdata_o <= {4{wdata_i[7:0]}};
                                mem_mask_o  <= 4'b0001 << addr_i[1:0];
                            end else begin
                                // SB without byte masking starts with a read.
                                mem_we_o    <= op_store && !is_byte_i;
                                mem_wdata_o <= wdata_i;
                                mem_mask_o  <= 4'hF;
                            end
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_o <= 1'b0;
                        if (store_q && (!byte_q || BYTE_MASK)) begin
                            state      <= DONE;
                            done_o     <= 1'b1;
                            mem_we_o   <= 1'b0;
                            mem_mask_o <= 4'hF;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_resp_valid_i) begin
                        if (!store_q) begin
                            state   <= DONE;
                            done_o  <= 1'b1;
                            rdata_o <= byte_q ? {{(DATA_WIDTH-8){1'b0}}, resp_byte}
                                              : mem_resp_data_i;
                        end else begin
                            state           <= RMW_WR;
                            mem_req_valid_o <= 1'b1;
                            mem_we_o        <= 1'b1;
                            mem_wdata_o     <= merged;
                            mem_mask_o      <= 4'hF;
                        end
                    end
                end
                RMW_WR: begin
                    if (mem_req_ready_i) begin
                        state           <= DONE;
                        done_o          <= 1'b1;
                        mem_req_valid_o <= 1'b0;
                        mem_we_o        <= 1'b0;
                    end
                end
                DONE: begin
                    // The pipeline advances this cycle; any op_valid_i is ignored.
                    state        <= IDLE;
                    done_o       <= 1'b0;
                    misaligned_o <= 1'b0;
                    mem_we_o     <= 1'b0;
                    mem_mask_o   <= 4'hF;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences data-memory accesses for load/store instructions flagged by the decode controller: LW, LBU, SW, SB.
- Sits between the execute stage and the data-memory port.
- Stalls the pipeline while an access is outstanding.
- Performs byte-lane steering, LBU zero-extension and SB read-modify-write.
- Holds at most one access in flight; drives a valid/ready request channel and accepts a valid-only response channel.

Parameters:
- ADDR_WIDTH, 32, byte address width of addr_i and mem_addr_o.
- DATA_WIDTH, 32, word width; only 32 is supported, giving 4 byte lanes.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- op_valid_i  input  1  execute stage presents a memory op (decode is_mem_op).
- is_load_i  input  1  op is a load (decode is_load_op).
- is_store_i  input  1  op is a store (decode is_store_op).
- is_byte_i  input  1  byte op: LBU/SB (decode is_byte_op).
- addr_i  input  ADDR_WIDTH  effective byte address.
- wdata_i  input  32  store data; SB uses bits [7:0].
- stall_o  output  1  pipeline must hold.
- done_o  output  1  one-cycle pulse; access complete.
- rdata_o  output  32  load result; valid when done_o=1.
- misaligned_o  output  1  one-cycle pulse with done_o; word access with addr[1:0]!=0.
- mem_req_valid_o  output  1  request valid.
- mem_req_ready_i  input  1  memory accepts request this cycle.
- mem_we_o  output  1  1 = write, 0 = read.
- mem_addr_o  output  ADDR_WIDTH  word-aligned address (addr[1:0] forced to 0).
- mem_wdata_o  output  32  write data.
- mem_mask_o  output  4  byte write enable, little-endian lane = addr[1:0].
- mem_resp_valid_i  input  1  read data valid.
- mem_resp_data_i  input  32  read data.

Behaviour:
- Reset: state=IDLE; all outputs 0 except mem_mask_o=4'hF; latched operands cleared.
- States: IDLE, REQ, WAIT, RMW_WR, DONE.
- IDLE:
  - If op_valid_i=1, latch is_load/is_store/is_byte/addr/wdata. stall_o=1 combinationally in that cycle.
  - Aligned op -> REQ. Word op with addr[1:0]!=0 -> DONE directly, no memory request; misaligned_o=1 and rdata_o=0 in DONE.
  - If is_load_i and is_store_i are both 1, treat as load.
- REQ:
  - mem_req_valid_o=1. mem_we_o=1 for SW only; for SB, see RMW and the optional feature.
  - Address, data, mask and we are held stable until mem_req_ready_i=1.
  - On ready: load or SB read -> WAIT; SW -> DONE.
- WAIT: wait for mem_resp_valid_i; a response in the same cycle as acceptance is not allowed.
  - LW: rdata = resp_data.
  - LBU: rdata = {24'b0, resp_data byte[addr[1:0]]}.
  - SB read: merge wdata[7:0] into lane addr[1:0] -> RMW_WR.
  - Any of the above then -> DONE.
- RMW_WR: mem_req_valid_o=1, mem_we_o=1, mem_wdata_o = merged word, mask 4'hF; on ready -> DONE.
- DONE:
  - done_o=1, stall_o=0, rdata_o valid; next state IDLE unconditionally.
  - op_valid_i is ignored in DONE, because the pipeline advances that cycle.
  - rdata_o holds its value until the next DONE.
- stall_o=1 in REQ, WAIT and RMW_WR.
- Minimum stall for an aligned load: 3 cycles (IDLE, REQ, WAIT), then DONE.
- mem_resp_valid_i outside WAIT is ignored, including a stale response after reset.
- Reset mid-operation: immediate return to IDLE; mem_req_valid_o drops asynchronously; no partial RMW write is issued.

Optional Feature:
- Macro: DMEM_BYTE_MASK_EN.
- Defined: SB issues a single write in REQ with mem_we_o=1, mem_wdata_o = wdata[7:0] replicated to all 4 lanes, mem_mask_o = one-hot(addr[1:0]); on ready -> DONE. RMW_WR is unreachable.
- Undefined: SB uses read-modify-write (REQ read, WAIT, RMW_WR), and mem_mask_o is always 4'hF.

Test Plan:
- LW addr=0x100, ready=1, resp 1 cycle later data=0xDEADBEEF -> req we=0 addr=0x100; done_o at cycle 3 after op; rdata_o=0xDEADBEEF; stall_o high for cycles 0-2.
- LBU addr=0x203, resp=0x11223344 -> mem_addr_o=0x200; rdata_o=0x00000011.
- SW addr=0x40 data=0xCAFEF00D, ready low 3 cycles -> request fields stable for all 4 valid cycles; done_o the cycle after accept; no response is awaited.
- SB addr=0x81 data=0xAB:
  - Without the macro: read 0x80 returns 0x55667788 -> write 0x5566AB88 with mask 4'hF.
  - With DMEM_BYTE_MASK_EN: single write, data 0xABABABAB, mask 4'b0010.
- LW addr=0x102 -> no mem_req_valid_o; done_o=1 and misaligned_o=1 one cycle after op; rdata_o=0.
- Assert reset while in WAIT, then pulse mem_resp_valid_i -> state IDLE, all outputs at reset values, no done_o; the next LW completes normally.
